display_scan_capture: RTL and testbench

- Receive-side monitor for the team's multiplexed 4-digit 7-segment interface.
- Watches the active-low anode strobes and active-low cathode lines that the scan driver produces.
- Reconstructs the 4 displayed hex digits and reports each complete frame as a 16-bit value.
- Flags scan-protocol violations. Sits beside the display driver on-chip for self-check, and in benches as the interface checker.

---
 rtl/disp_pkg.sv | 37 +++
 rtl/seg_glyph_decode.sv | 35 +++
 rtl/display_scan_capture.sv | 194 +++++++++++++++++++
 tb/tb_display_scan_capture.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
package disp_pkg;

    // Active-low anode codes, one digit enabled at a time
    localparam logic [3:0] AN_D0    = 4'b1110;
    localparam logic [3:0] AN_D1    = 4'b1101;
    localparam logic [3:0] AN_D2    = 4'b1011;
    localparam logic [3:0] AN_D3    = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Active-low cathode patterns, seg[0]=a .. seg[6]=g
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    // Next digit position the frame tracker is waiting for
    typedef enum logic [1:0] {
        EXP_D0 = 2'd0,
        EXP_D1 = 2'd1,
        EXP_D2 = 2'd2,
        EXP_D3 = 2'd3
    } exp_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Exact-match decode of an active-low 7-segment pattern to a hex nibble.
module seg_glyph_decode
    import disp_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       valid
);

    // Table lookup; unknown patterns report nibble 0 and valid low
    always_comb begin
        nibble = '0;
        valid  = 1'b1;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_scan_capture.sv
// Monitors a multiplexed 4-digit 7-segment scan, rebuilds each frame and
// flags protocol violations (out-of-order digits, multiple anodes, stalls).
module display_scan_capture
    import disp_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        glyph_err,
    output logic        order_err,
    output logic        multi_err,
    output logic        stale
);

    localparam logic [15:0] SETTLE_W  = 16'(SETTLE_CYCLES);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [15:0] settle_q, settle_now;
    logic        captured_q;
    logic        new_win, seg_chg, onehot, multi_win, capture, timeout;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic        nib_ok;
    logic [15:0] idle_q, idle_nx;

    exp_t        expected, expected_nx;
    logic [11:0] shadow, shadow_nx;
    logic        gflag, gflag_nx;
    logic        commit, commit_nx;
    logic [15:0] frame_q, frame_nx;
    logic        fglyph_q, fglyph_nx;
    logic        order_nx;

    seg_glyph_decode u_dec (
        .seg    (seg_q),
        .nibble (nib),
        .valid  (nib_ok)
    );

    // Register the pins once, plus a delayed copy for change detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q  <= AN_BLANK;
            seg_q <= '1;
            an_d  <= AN_BLANK;
            seg_d <= '1;
        end else begin
            an_q  <= an;
            seg_q <= seg;
            an_d  <= an_q;
            seg_d <= seg_q;
        end
    end

    // Anode classification: single digit, blank, or 2+ anodes low
    always_comb begin
        idx       = 2'd0;
        onehot    = 1'b1;
        multi_win = 1'b0;
        case (an_q)
            AN_D0:    idx = 2'd0;
            AN_D1:    idx = 2'd1;
            AN_D2:    idx = 2'd2;
            AN_D3:    idx = 2'd3;
            AN_BLANK: onehot = 1'b0;
            default: begin
                onehot    = 1'b0;
                multi_win = 1'b1;
            end
        endcase
    end

    // Window tracking: settle count, capture strobe and idle timeout
    always_comb begin
        new_win    = (an_q != an_d);
        seg_chg    = (seg_q != seg_d);
        settle_now = (new_win || seg_chg) ? '0
                   : ((settle_q == '1) ? settle_q : settle_q + 16'd1);
        capture    = onehot && (settle_now == SETTLE_W) && (new_win || !captured_q);
        idle_nx    = capture ? '0
                   : ((idle_q == TIMEOUT_W) ? idle_q : idle_q + 16'd1);
        timeout    = !capture && (idle_nx == TIMEOUT_W);
    end

    // Settle counter, one-capture-per-window flag and idle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_q   <= '0;
            captured_q <= 1'b0;
            idle_q     <= '0;
        end else begin
            settle_q   <= settle_now;
            captured_q <= new_win ? capture : (captured_q || capture);
            idle_q     <= idle_nx;
        end
    end

    // Frame tracker next state; a completed frame is snapshotted and
    // expected returns to 0 immediately so back-to-back scans keep up
    always_comb begin
        expected_nx = expected;
        shadow_nx   = shadow;
        gflag_nx    = gflag;
        commit_nx   = 1'b0;
        frame_nx    = frame_q;
        fglyph_nx   = fglyph_q;
        order_nx    = 1'b0;
        if (capture) begin
            if (idx == expected) begin
                case (idx)
                    2'd0: shadow_nx[3:0]  = nib;
                    2'd1: shadow_nx[7:4]  = nib;
                    2'd2: shadow_nx[11:8] = nib;
                    default: ;
                endcase
                if (idx == 2'd3) begin
                    commit_nx   = 1'b1;
                    frame_nx    = {nib, shadow};
                    fglyph_nx   = gflag || !nib_ok;
                    gflag_nx    = 1'b0;
                    expected_nx = EXP_D0;
                end else begin
                    gflag_nx    = gflag || !nib_ok;
                    expected_nx = exp_t'(idx + 2'd1);
                end
            end else begin
                order_nx = 1'b1;
                if (idx == 2'd0) begin
                    shadow_nx[3:0] = nib;
                    gflag_nx       = !nib_ok;
                    expected_nx    = EXP_D1;
                end else begin
                    gflag_nx    = 1'b0;
                    expected_nx = EXP_D0;
                end
            end
        end else if (timeout) begin
            expected_nx = EXP_D0;
            gflag_nx    = 1'b0;
        end
    end

    // Frame tracker state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected <= EXP_D0;
            shadow   <= '0;
            gflag    <= 1'b0;
            commit   <= 1'b0;
            frame_q  <= '0;
            fglyph_q <= 1'b0;
        end else begin
            expected <= expected_nx;
            shadow   <= shadow_nx;
            gflag    <= gflag_nx;
            commit   <= commit_nx;
            frame_q  <= frame_nx;
            fglyph_q <= fglyph_nx;
        end
    end

    // Published outputs: frame one edge after the digit3 capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value       <= '0;
            frame_valid <= 1'b0;
            glyph_err   <= 1'b0;
            order_err   <= 1'b0;
            multi_err   <= 1'b0;
            stale       <= 1'b1;
        end else begin
            frame_valid <= commit;
            order_err   <= order_nx;
            multi_err   <= new_win && multi_win;
            if (commit) begin
                value     <= frame_q;
                glyph_err <= fglyph_q;
                stale     <= 1'b0;
            end else if (timeout) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_capture.sv
// Self-checking bench for display_scan_capture: directed scenarios plus a
// randomized window stream compared against a transaction-level model.
module tb_display_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] v0, v2;
    logic        fv0, ge0, oe0, me0, st0;
    logic        fv2, ge2, oe2, me2, st2;

    int total = 0;
    int bad   = 0;

    logic [6:0] gtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display_scan_capture #(.SETTLE_CYCLES(0), .TIMEOUT_CYCLES(64)) dut0 (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .value(v0), .frame_valid(fv0),
        .glyph_err(ge0), .order_err(oe0), .multi_err(me0), .stale(st0));

    display_scan_capture #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(64)) dut2 (
        .clk(clk), .reset(reset), .an(an), .seg(seg), .value(v2), .frame_valid(fv2),
        .glyph_err(ge2), .order_err(oe2), .multi_err(me2), .stale(st2));

    always #5 clk = ~clk;

    // event counters and frame log, sampled on the falling edge
    int fv_cnt0, oe_cnt0, me_cnt0, fv_cnt2, oe_cnt2;
    bit mon_en = 1'b0;
    logic [16:0] mon_frames[$];

    always @(negedge clk) begin
        if (fv0) begin
            fv_cnt0++;
            if (mon_en) mon_frames.push_back({ge0, v0});
        end
        if (oe0) oe_cnt0++;
        if (me0) me_cnt0++;
        if (fv2) fv_cnt2++;
        if (oe2) oe_cnt2++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] r;
        r = 4'hF;
        r[d[1:0]] = 1'b0;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic win(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) tick();
    endtask

    task automatic clr();
        fv_cnt0 = 0; oe_cnt0 = 0; me_cnt0 = 0; fv_cnt2 = 0; oe_cnt2 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; an = 4'hF; seg = 7'h7F;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic scan(input logic [6:0] g0, g1, g2, g3);
        win(an_of(0), g0, 1);
        win(an_of(1), g1, 1);
        win(an_of(2), g2, 1);
        win(an_of(3), g3, 1);
    endtask

    task automatic test_reset();
        reset = 1'b1; an = 4'hF; seg = 7'h7F;
        tick(); tick();
        total++;
        if ({v0, fv0, ge0, oe0, me0, st0} !== {16'h0, 5'b00001}) begin
            bad++; $display("FAIL reset_dut0 got=%h req=%h", {v0, fv0, ge0, oe0, me0, st0}, {16'h0, 5'b00001});
        end
        total++;
        if ({v2, fv2, ge2, oe2, me2, st2} !== {16'h0, 5'b00001}) begin
            bad++; $display("FAIL reset_dut2 got=%h req=%h", {v2, fv2, ge2, oe2, me2, st2}, {16'h0, 5'b00001});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_scan();
        int first_k;
        logic st_k1;
        clr();
        scan(gtab[1], gtab[2], gtab[3], gtab[4]);
        an = 4'hF;
        first_k = 0;
        st_k1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) st_k1 = st0;
            if (fv0 && first_k == 0) first_k = k;
        end
        total++;
        if (first_k !== 2) begin bad++; $display("FAIL scan_latency got=%0d req=2", first_k); end
        total++;
        if (st_k1 !== 1'b1) begin bad++; $display("FAIL scan_stale_before got=%b req=1", st_k1); end
        total++;
        if (v0 !== 16'h4321) begin bad++; $display("FAIL scan_value got=%h req=4321", v0); end
        total++;
        if (ge0 !== 1'b0 || st0 !== 1'b0) begin bad++; $display("FAIL scan_flags ge=%b st=%b req=0,0", ge0, st0); end
        clr();
        scan(gtab[1], gtab[2], gtab[3], gtab[4]);
        scan(gtab[1], gtab[2], gtab[3], gtab[4]);
        win(4'hF, 7'h7F, 4);
        total++;
        if (fv_cnt0 !== 2 || oe_cnt0 !== 0) begin
            bad++; $display("FAIL scan_b2b fv=%0d oe=%0d req=2,0", fv_cnt0, oe_cnt0);
        end
    endtask

    task automatic test_glyph();
        clr();
        scan(gtab[1], gtab[2], 7'h7F, gtab[4]);
        win(4'hF, 7'h7F, 4);
        total++;
        if (v0 !== 16'h4021 || ge0 !== 1'b1 || fv_cnt0 !== 1) begin
            bad++; $display("FAIL glyph_bad v=%h ge=%b fv=%0d req=4021,1,1", v0, ge0, fv_cnt0);
        end
        scan(gtab[1], gtab[2], gtab[3], gtab[4]);
        win(4'hF, 7'h7F, 4);
        total++;
        if (v0 !== 16'h4321 || ge0 !== 1'b0) begin
            bad++; $display("FAIL glyph_clear v=%h ge=%b req=4321,0", v0, ge0);
        end
    endtask

    task automatic test_order();
        logic oe_at3;
        clr();
        win(an_of(0), gtab[9], 1);
        win(an_of(1), gtab[8], 1);
        win(an_of(3), gtab[6], 1);
        win(an_of(2), gtab[7], 1);
        oe_at3 = oe0;
        win(4'hF, 7'h7F, 4);
        total++;
        if (oe_at3 !== 1'b1) begin bad++; $display("FAIL order_pulse_d3 got=%b req=1", oe_at3); end
        total++;
        if (oe_cnt0 !== 2 || fv_cnt0 !== 0) begin
            bad++; $display("FAIL order_counts oe=%0d fv=%0d req=2,0", oe_cnt0, fv_cnt0);
        end
        clr();
        scan(gtab[9], gtab[8], gtab[7], gtab[6]);
        win(4'hF, 7'h7F, 4);
        total++;
        if (fv_cnt0 !== 1 || v0 !== 16'h6789) begin
            bad++; $display("FAIL order_recover fv=%0d v=%h req=1,6789", fv_cnt0, v0);
        end
    endtask

    task automatic test_multi();
        clr();
        win(an_of(0), gtab[5], 1);
        win(an_of(1), gtab[6], 1);
        win(4'b1100, gtab[0], 5);
        win(an_of(2), gtab[7], 1);
        win(an_of(3), gtab[8], 1);
        win(4'hF, 7'h7F, 4);
        total++;
        if (me_cnt0 !== 1) begin bad++; $display("FAIL multi_count got=%0d req=1", me_cnt0); end
        total++;
        if (oe_cnt0 !== 0 || fv_cnt0 !== 1 || v0 !== 16'h8765) begin
            bad++; $display("FAIL multi_frame oe=%0d fv=%0d v=%h req=0,1,8765", oe_cnt0, fv_cnt0, v0);
        end
    endtask

    task automatic test_settle();
        logic fv_at;
        do_reset();
        clr();
        win(an_of(0), gtab[1], 1);
        win(an_of(0), gtab[9], 3);
        win(an_of(1), gtab[2], 4);
        win(an_of(2), gtab[3], 4);
        win(an_of(3), gtab[4], 4);
        win(4'hF, 7'h7F, 1);
        fv_at = fv2;
        win(4'hF, 7'h7F, 3);
        total++;
        if (fv_at !== 1'b1) begin bad++; $display("FAIL settle_latency got=%b req=1", fv_at); end
        total++;
        if (v2 !== 16'h4329 || fv_cnt2 !== 1 || oe_cnt2 !== 0) begin
            bad++; $display("FAIL settle_glitch v=%h fv=%0d oe=%0d req=4329,1,0", v2, fv_cnt2, oe_cnt2);
        end
        clr();
        win(an_of(0), gtab[1], 4);
        win(an_of(1), gtab[2], 2);
        win(an_of(2), gtab[3], 4);
        win(4'hF, 7'h7F, 4);
        total++;
        if (oe_cnt2 !== 1 || fv_cnt2 !== 0) begin
            bad++; $display("FAIL settle_short oe=%0d fv=%0d req=1,0", oe_cnt2, fv_cnt2);
        end
    endtask

    task automatic test_timeout();
        logic st65, st66;
        do_reset();
        scan(gtab[10], gtab[11], gtab[12], gtab[13]);
        win(4'hF, 7'h7F, 4);
        total++;
        if (v0 !== 16'hDCBA || st0 !== 1'b0) begin bad++; $display("FAIL tmo_setup v=%h st=%b req=dcba,0", v0, st0); end
        win(an_of(0), gtab[1], 1);
        win(an_of(1), gtab[2], 1);
        an = 4'hF;
        st65 = 1'bx; st66 = 1'bx;
        for (int k = 2; k <= 66; k++) begin
            tick();
            if (k == 65) st65 = st0;
            if (k == 66) st66 = st0;
        end
        total++;
        if (st65 !== 1'b0 || st66 !== 1'b1) begin
            bad++; $display("FAIL tmo_edge st@65=%b st@66=%b req=0,1", st65, st66);
        end
        total++;
        if (v0 !== 16'hDCBA) begin bad++; $display("FAIL tmo_hold v=%h req=dcba", v0); end
        clr();
        win(an_of(2), gtab[3], 1);
        win(4'hF, 7'h7F, 3);
        total++;
        if (oe_cnt0 !== 1) begin bad++; $display("FAIL tmo_expected_cleared oe=%0d req=1", oe_cnt0); end
        scan(gtab[1], gtab[2], gtab[3], gtab[4]);
        win(4'hF, 7'h7F, 4);
        win(an_of(0), gtab[5], 1);
        win(an_of(1), gtab[6], 1);
        reset = 1'b1;
        #1;
        total++;
        if ({v0, fv0, ge0, oe0, me0, st0} !== {16'h0, 5'b00001}) begin
            bad++; $display("FAIL midframe_reset got=%h req=%h", {v0, fv0, ge0, oe0, me0, st0}, {16'h0, 5'b00001});
        end
        an = 4'hF;
        tick();
        reset = 1'b0;
        tick();
        clr();
        win(an_of(2), gtab[7], 1);
        win(an_of(3), gtab[8], 1);
        win(4'hF, 7'h7F, 4);
        total++;
        if (fv_cnt0 !== 0 || oe_cnt0 !== 2) begin
            bad++; $display("FAIL midframe_discard fv=%0d oe=%0d req=0,2", fv_cnt0, oe_cnt0);
        end
    endtask

    // transaction-level reference: one call per captured digit window
    int m_exp, m_order, m_multi;
    bit m_flag;
    logic [3:0] m_sh [3];
    logic [16:0] exp_frames[$];

    task automatic m_cap(input int i, input logic [6:0] g);
        logic [3:0] n;
        bit ok;
        logic [16:0] f;
        n = 4'h0; ok = 1'b0;
        for (int k = 0; k < 16; k++) if (gtab[k] == g) begin n = 4'(k); ok = 1'b1; end
        if (i == m_exp) begin
            if (i == 3) begin
                f = {(m_flag || !ok), n, m_sh[2], m_sh[1], m_sh[0]};
                exp_frames.push_back(f);
                m_flag = 1'b0; m_exp = 0;
            end else begin
                m_sh[i] = n; m_flag = m_flag || !ok; m_exp = i + 1;
            end
        end else begin
            m_order++;
            if (i == 0) begin m_sh[0] = n; m_flag = !ok; m_exp = 1; end
            else begin m_flag = 1'b0; m_exp = 0; end
        end
    endtask

    task automatic test_random();
        logic [3:0] prev_an, a;
        logic [6:0] g;
        int r, idx, len, since, nf;
        do_reset();
        clr();
        mon_frames.delete(); exp_frames.delete();
        m_exp = 0; m_order = 0; m_multi = 0; m_flag = 1'b0;
        prev_an = 4'hF; since = 0;
        mon_en = 1'b1;
        for (int w = 0; w < 300; w++) begin
            r = $urandom_range(0, 9);
            len = $urandom_range(1, 3);
            g = 7'($urandom);
            if (r == 0 && prev_an != 4'hF && since < 40) begin
                win(4'hF, g, len); prev_an = 4'hF; since += len;
            end else if (r <= 2 && since < 40) begin
                do a = 4'($urandom); while ($countones(~a) < 2 || a == prev_an);
                m_multi++;
                win(a, g, len); prev_an = a; since += len;
            end else begin
                idx = ($urandom_range(0, 4) != 0) ? m_exp : $urandom_range(0, 3);
                a = an_of(idx);
                if (a == prev_an) win(4'hF, g, 1);
                if ($urandom_range(0, 6) != 0) g = gtab[$urandom_range(0, 15)];
                m_cap(idx, g);
                win(a, g, len); prev_an = a; since = len;
            end
        end
        win(4'hF, 7'h7F, 6);
        mon_en = 1'b0;
        total++;
        if (mon_frames.size() !== exp_frames.size()) begin
            bad++; $display("FAIL rand_frame_count got=%0d req=%0d", mon_frames.size(), exp_frames.size());
        end
        nf = (mon_frames.size() < exp_frames.size()) ? mon_frames.size() : exp_frames.size();
        for (int i = 0; i < nf; i++) begin
            total++;
            if (mon_frames[i] !== exp_frames[i]) begin
                bad++; $display("FAIL rand_frame[%0d] got=%h req=%h", i, mon_frames[i], exp_frames[i]);
            end
        end
        total++;
        if (oe_cnt0 !== m_order) begin bad++; $display("FAIL rand_order got=%0d req=%0d", oe_cnt0, m_order); end
        total++;
        if (me_cnt0 !== m_multi) begin bad++; $display("FAIL rand_multi got=%0d req=%0d", me_cnt0, m_multi); end
    endtask

    initial begin
        reset = 1'b0; an = 4'hF; seg = 7'h7F;
        test_reset();
        test_scan();
        test_glyph();
        test_order();
        test_multi();
        test_settle();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
